asym_flush_fifo: RTL and testbench
==================================

Name: asym_flush_fifo

Overview:
- Parametrised narrow-write / wide-read FIFO with snapshot flush. It generalises the fixed 4-to-32-bit, 128-bit flush FIFO to any write width, read width and capacity.
- Accepts WR_W-bit beats and delivers RD_W-bit words on the same cycle as the read.
- On flush, drains every beat stored up to and including the flush-start cycle, zero-padding the final partial word. Writes continue throughout the flush.
- Sits between narrow producers (e.g. nibble streams) and word-wide consumers.

Parameters:
- WR_W, 4, write beat width in bits.
- RD_W, 32, read word width in bits; must be a multiple of WR_W, and RATIO=RD_W/WR_W must be >= 2.
- CAP_BITS, 128, exact storage capacity in bits; must be a multiple of RD_W. DEPTH=CAP_BITS/WR_W must be a power of two.
- Illegal parameter combinations raise an elaboration-time $error.

Ports:
- clk  in  1  clock, all flops posedge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid_i  in  1  write beat valid.
- wr_data_i  in  WR_W  write beat.
- rd_valid_i  in  1  read strobe; legal only while data_avail_o=1.
- rd_data_o  out  RD_W  read word, same cycle as rd_valid_i.
- data_avail_o  out  1  a read may be issued this cycle.
- flush_i  in  1  flush request; held high until flush_done_o is seen.
- flush_done_o  out  1  one-cycle pulse, flush complete.
- flush_active_o  out  1  flush being serviced.
- empty_o  out  1  level=0.
- full_o  out  1  level=DEPTH.
- level_o  out  $clog2(DEPTH+1)  beats stored.

Behaviour:
- Reset values: empty_o=1; full_o, data_avail_o, flush_done_o, flush_active_o = 0; rd_data_o=0; level_o=0. Pointers clear to 0 and the FSM goes to FL_IDLE.
- Storage array needs no reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, in beats. Bit-for-bit wrap; level = wr_ptr - rd_ptr.
- Write: accepted when wr_valid_i and !full_o, into mem[wr_ptr]. A write while full is dropped and causes no state change.
- Word packing: the oldest beat goes in rd_data_o[WR_W-1:0]; beat i maps to bits [i*WR_W +: WR_W].
- Normal read (FL_IDLE), data_avail_o = (level >= RATIO):
  - rd_valid_i returns RATIO beats and advances rd_ptr by RATIO.
  - rd_data_o = 0 whenever no legal read is in progress.
- Flush start:
  - Occurs when the FSM is in FL_IDLE, flush_i=1 and flush_q=0 (rising edge; flush_q is flush_i registered).
  - Captures flush_end = wr_ptr + (write accepted this cycle ? 1 : 0). Next state is FL_ACTIVE.
  - A normal read on the start cycle is legal and uses the normal rule.
- FL_ACTIVE:
  - rem = flush_end - rd_ptr; data_avail_o = (rem != 0) || (level >= RATIO).
  - If rem >= RATIO, a read returns a full word.
  - If 0 < rem < RATIO, a read returns rem beats, upper beats = 0, and advances rd_ptr by rem.
  - If rem = 0, the read path uses the normal rule.
  - Beats written after the start cycle are never part of the flush; they may complete a word that is read normally after rem = 0.
- FL_ACTIVE -> FL_DONE when (rem=0) or (a read this cycle makes rem 0).
- FL_DONE: flush_done_o=1 for exactly one cycle, then the FSM goes to FL_IDLE unconditionally.
- A new flush needs flush_i to go low and then rise again.
- flush_active_o = (state != FL_IDLE).
- Level update: level_next = level + wr_accepted - beats_read. Simultaneous read and write is always legal.
- full_o and empty_o are combinational from the pointers.
- Reset mid-flush: immediate return to reset values; no flush_done_o is issued and the requester must re-assert.
- Protocol violations (rd_valid_i without data_avail_o, flush on empty) are ignored by the RTL and flagged by bench assertions.

Decomposition:
- asym_fifo_pkg:
  - flush_state_t enum {FL_IDLE, FL_ACTIVE, FL_DONE}.
  - Function beats_to_word(rem) producing the lane-valid mask.
- Sub-module asym_fifo_flush_ctrl: flush_q edge detect, flush_end capture, FSM and rem computation. Outputs flush_active, rem and flush_done.
- Top level holds storage, pointers and the packing/padding mux.

Test Plan (defaults WR_W=4, RD_W=32, CAP_BITS=128):
- Write beats 1..8 -> data_avail_o=1 after the 8th edge; read gives rd_data_o=0x87654321, then empty_o=1, level_o=0.
- Write 32 beats -> full_o=1, level_o=32; a 33rd write is dropped; 4 reads return the words in order and end with empty_o=1.
- Write A,B,C; on the flush_i rise cycle write D; write E the next cycle:
  - read gives 0x0000DCBA;
  - flush_done_o pulses the following cycle;
  - level_o=1 and data_avail_o=0.
- Write beats 1..B (11), then flush:
  - read 1 gives 0x87654321;
  - read 2 gives 0x00000BA9;
  - done pulses one cycle later;
  - the FSM returns to FL_IDLE and flush_active_o=0.
- Wrap: 5 rounds of 24 writes / 3 reads with a flush in round 3 -> data ordered correctly across pointer wrap; level_o matches the model every cycle.
- Reset asserted during FL_ACTIVE with 5 beats stored -> all outputs at reset values; no flush_done_o; a new flush after re-fill behaves per scenario 3.

Source files
------------

// File: rtl/asym_fifo_pkg.sv
// Shared types and helpers for the asymmetric narrow-write / wide-read flush FIFO.
package asym_fifo_pkg;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_ACTIVE,
        FL_DONE
    } flush_state_t;

    // Upper bound on beats per read word that the lane mask can describe.
    localparam int unsigned MaxLanes = 64;

    function automatic logic [MaxLanes-1:0] beats_to_word(input int unsigned n);
        logic [MaxLanes-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            mask[i] = (i < n);
        end
        return mask;
    endfunction

endpackage

// File: rtl/asym_fifo_flush_ctrl.sv
// Flush sequencer: detects the flush request edge, snapshots the write pointer and
// tracks how many snapshot beats remain to be drained.
module asym_fifo_flush_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int unsigned PtrW  = 6,
    parameter int unsigned Ratio = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [PtrW-1:0] wr_ptr_i,
    input  logic            wr_acc_i,
    input  logic [PtrW-1:0] rd_ptr_i,
    input  logic            rd_fire_i,
    output logic [PtrW-1:0] rem_o,
    output logic            flush_active_o,
    output logic            flush_done_o
);

    localparam logic [PtrW-1:0] RatioP = PtrW'(Ratio);

    flush_state_t    state_q, state_d;
    logic            flush_q;
    logic [PtrW-1:0] flush_end_q, flush_end_d;
    logic [PtrW-1:0] rem;

    assign rem = flush_end_q - rd_ptr_i;

    always_comb begin
        state_d     = state_q;
        flush_end_d = flush_end_q;
        unique case (state_q)
            FL_IDLE: begin
                // The beat written on the start cycle belongs to the snapshot.
                if (flush_i && !flush_q) begin
                    state_d     = FL_ACTIVE;
                    flush_end_d = wr_ptr_i + PtrW'(wr_acc_i);
                end
            end
            FL_ACTIVE: begin
                if ((rem == '0) || (rd_fire_i && (rem <= RatioP))) begin
                    state_d = FL_DONE;
                end
            end
            FL_DONE: state_d = FL_IDLE;
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FL_IDLE;
            flush_q     <= 1'b0;
            flush_end_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_i;
            flush_end_q <= flush_end_d;
        end
    end

    // Outside FL_ACTIVE the snapshot is stale, so report nothing left to drain.
    assign rem_o          = (state_q == FL_ACTIVE) ? rem : '0;
    assign flush_active_o = (state_q != FL_IDLE);
    assign flush_done_o   = (state_q == FL_DONE);

endmodule

// File: rtl/asym_flush_fifo.sv
// Narrow-write / wide-read FIFO with snapshot flush that drains a zero-padded
// final partial word while writes keep flowing.
module asym_flush_fifo
    import asym_fifo_pkg::*;
#(
    parameter int unsigned WR_W     = 4,
    parameter int unsigned RD_W     = 32,
    parameter int unsigned CAP_BITS = 128
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_valid_i,
    input  logic [WR_W-1:0]                     wr_data_i,
    input  logic                                rd_valid_i,
    output logic [RD_W-1:0]                     rd_data_o,
    output logic                                data_avail_o,
    input  logic                                flush_i,
    output logic                                flush_done_o,
    output logic                                flush_active_o,
    output logic                                empty_o,
    output logic                                full_o,
    output logic [$clog2(CAP_BITS/WR_W+1)-1:0]  level_o
);

    localparam int unsigned Ratio = RD_W / WR_W;
    localparam int unsigned Depth = CAP_BITS / WR_W;
    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned LvlW  = $clog2(Depth + 1);

    localparam logic [PtrW-1:0] RatioP = PtrW'(Ratio);
    localparam logic [PtrW-1:0] DepthP = PtrW'(Depth);

    if ((RD_W % WR_W) != 0 || Ratio < 2) begin : g_bad_ratio
        $error("asym_flush_fifo: RD_W must be a multiple of WR_W with RD_W/WR_W >= 2");
    end
    if ((CAP_BITS % RD_W) != 0 || CAP_BITS < RD_W) begin : g_bad_cap
        $error("asym_flush_fifo: CAP_BITS must be a non-zero multiple of RD_W");
    end
    if ((Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("asym_flush_fifo: CAP_BITS/WR_W must be a power of two");
    end
    if (Ratio > MaxLanes) begin : g_bad_lanes
        $error("asym_flush_fifo: RD_W/WR_W exceeds the supported lane count");
    end

    logic [WR_W-1:0]     mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     level;
    logic [PtrW-1:0]     rem;
    logic [PtrW-1:0]     rd_beats;
    logic [MaxLanes-1:0] lane_mask;
    logic [AddrW-1:0]    rd_idx;
    logic                wr_acc;
    logic                rd_fire;
    logic                draining;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level == DepthP);
    assign empty_o = (level == '0);
    assign level_o = LvlW'(level);
    assign wr_acc  = wr_valid_i && !full_o;

    asym_fifo_flush_ctrl #(
        .PtrW  (PtrW),
        .Ratio (Ratio)
    ) u_flush_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .wr_ptr_i       (wr_ptr_q),
        .wr_acc_i       (wr_acc),
        .rd_ptr_i       (rd_ptr_q),
        .rd_fire_i      (rd_fire),
        .rem_o          (rem),
        .flush_active_o (flush_active_o),
        .flush_done_o   (flush_done_o)
    );

    // Snapshot beats take priority; once drained the normal full-word rule applies.
    assign draining     = (rem != '0);
    assign data_avail_o = draining || (level >= RatioP);
    assign rd_fire      = rd_valid_i && data_avail_o;
    assign rd_beats     = (draining && (rem < RatioP)) ? rem : RatioP;
    assign lane_mask    = beats_to_word(32'(rd_beats));

    always_comb begin
        rd_data_o = '0;
        rd_idx    = '0;
        if (rd_fire) begin
            for (int unsigned i = 0; i < Ratio; i++) begin
                rd_idx = rd_ptr_q[AddrW-1:0] + AddrW'(i);
                if (lane_mask[i]) begin
                    rd_data_o[i*WR_W +: WR_W] = mem_q[rd_idx];
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(wr_acc);
        rd_ptr_d = rd_fire ? (rd_ptr_q + rd_beats) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_asym_flush_fifo.sv
// Self-checking bench for asym_flush_fifo: directed scenarios plus randomized
// traffic against a queue-based model of the FIFO and its flush snapshot.
module tb_asym_flush_fifo;

    localparam int WR_W     = 4;
    localparam int RD_W     = 32;
    localparam int CAP_BITS = 128;
    localparam int RATIO    = RD_W / WR_W;
    localparam int DEPTH    = CAP_BITS / WR_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid_i;
    logic [WR_W-1:0] wr_data_i;
    logic            rd_valid_i;
    logic [RD_W-1:0] rd_data_o;
    logic            data_avail_o;
    logic            flush_i;
    logic            flush_done_o;
    logic            flush_active_o;
    logic            empty_o;
    logic            full_o;
    logic [5:0]      level_o;

    asym_flush_fifo #(
        .WR_W     (WR_W),
        .RD_W     (RD_W),
        .CAP_BITS (CAP_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid_i     (wr_valid_i),
        .wr_data_i      (wr_data_i),
        .rd_valid_i     (rd_valid_i),
        .rd_data_o      (rd_data_o),
        .data_avail_o   (data_avail_o),
        .flush_i        (flush_i),
        .flush_done_o   (flush_done_o),
        .flush_active_o (flush_active_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .level_o        (level_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: stored beats oldest-first, plus how many of them the active flush still owns.
    logic [WR_W-1:0] q[$];
    int              flush_left;
    bit              flushing;
    bit              done_pend;
    bit              fl_prev;

    logic [31:0] obs_rd;
    bit          obs_av, obs_done, obs_active, obs_full, obs_empty;
    int          obs_level;

    bit r_wr, r_rd, r_fl;
    int low_cnt;
    logic fl_seen_q = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_avail();
        return (flushing && flush_left != 0) || (q.size() >= RATIO);
    endfunction

    task automatic cyc(input bit wr, input logic [WR_W-1:0] d, input bit rd, input bit fl);
        int          n;
        int          sz;
        bit          exp_av, fire, wacc, start;
        logic [31:0] exp_rd;
        @(negedge clk);
        wr_valid_i = wr;
        wr_data_i  = d;
        rd_valid_i = rd;
        flush_i    = fl;
        #1;
        sz     = q.size();
        exp_av = model_avail();
        fire   = rd && exp_av;
        n      = (flushing && flush_left != 0 && flush_left < RATIO) ? flush_left : RATIO;
        exp_rd = '0;
        if (fire) begin
            for (int i = 0; i < n; i++) exp_rd[i*WR_W +: WR_W] = q[i];
        end
        check_eq("avail", 32'(data_avail_o), 32'(exp_av));
        check_eq("rd_data", rd_data_o, exp_rd);
        check_eq("level", 32'(level_o), 32'(sz));
        check_eq("full", 32'(full_o), 32'(sz == DEPTH));
        check_eq("empty", 32'(empty_o), 32'(sz == 0));
        check_eq("active", 32'(flush_active_o), 32'(flushing || done_pend));
        check_eq("done", 32'(flush_done_o), 32'(done_pend));
        obs_rd     = rd_data_o;
        obs_av     = data_avail_o;
        obs_done   = flush_done_o;
        obs_active = flush_active_o;
        obs_full   = full_o;
        obs_empty  = empty_o;
        obs_level  = int'(level_o);
        @(posedge clk);
        wacc  = wr && (sz < DEPTH);
        start = !flushing && !done_pend && fl && !fl_prev;
        if (done_pend) done_pend = 1'b0;
        if (flushing) begin
            if (flush_left == 0) begin
                flushing  = 1'b0;
                done_pend = 1'b1;
            end else if (fire) begin
                flush_left -= n;
                if (flush_left == 0) begin
                    flushing  = 1'b0;
                    done_pend = 1'b1;
                end
            end
        end
        if (fire) repeat (n) void'(q.pop_front());
        if (start) begin
            flushing   = 1'b1;
            flush_left = sz + int'(wacc) - (fire ? n : 0);
        end
        if (wacc) q.push_back(d);
        fl_prev = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        rd_valid_i = 1'b0;
        flush_i    = 1'b0;
        #1;
        check_eq("reset_empty", 32'(empty_o), 32'd1);
        check_eq("reset_full", 32'(full_o), 32'd0);
        check_eq("reset_avail", 32'(data_avail_o), 32'd0);
        check_eq("reset_done", 32'(flush_done_o), 32'd0);
        check_eq("reset_active", 32'(flush_active_o), 32'd0);
        check_eq("reset_rd_data", rd_data_o, 32'd0);
        check_eq("reset_level", 32'(level_o), 32'd0);
        q.delete();
        flushing   = 1'b0;
        done_pend  = 1'b0;
        flush_left = 0;
        fl_prev    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Write A,B,C; write D on the flush rise; write E while the 4-beat tail is read.
    task automatic scen_partial();
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'hB, 1'b0, 1'b0);
        cyc(1'b1, 4'hC, 1'b0, 1'b0);
        cyc(1'b1, 4'hD, 1'b0, 1'b1);
        cyc(1'b1, 4'hE, 1'b1, 1'b1);
        check_eq("partial_word", obs_rd, 32'h0000_DCBA);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        check_eq("partial_done", 32'(obs_done), 32'd1);
        check_eq("partial_level", 32'(obs_level), 32'd1);
        check_eq("partial_avail", 32'(obs_av), 32'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("partial_idle", 32'(obs_active), 32'd0);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            if (rd_valid_i) begin
                assert (data_avail_o) else $error("protocol: rd_valid_i without data_avail_o");
            end
            if (flush_i && !fl_seen_q && !flush_active_o) begin
                assert (!(empty_o && !wr_valid_i)) else $error("protocol: flush on empty FIFO");
            end
        end
        fl_seen_q <= flush_i;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        rd_valid_i = 1'b0;
        flush_i    = 1'b0;
        flush_left = 0;
        flushing   = 1'b0;
        done_pend  = 1'b0;
        fl_prev    = 1'b0;
        do_reset();

        // One full word of beats 1..8.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("word1_avail", 32'(obs_av), 32'd1);
        check_eq("word1_data", obs_rd, 32'h8765_4321);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("word1_empty", 32'(obs_empty), 32'd1);
        check_eq("word1_level", 32'(obs_level), 32'd0);

        // Fill to capacity, drop an extra write, drain in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        check_eq("fill_full", 32'(obs_full), 32'd1);
        check_eq("fill_level", 32'(obs_level), 32'd32);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("fill_w0", obs_rd, 32'h7654_3210);
        check_eq("fill_drop", 32'(obs_level), 32'd32);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("fill_w1", obs_rd, 32'hFEDC_BA98);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("fill_w2", obs_rd, 32'h7654_3210);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("fill_w3", obs_rd, 32'hFEDC_BA98);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("fill_empty", 32'(obs_empty), 32'd1);

        do_reset();
        scen_partial();

        // Eleven beats: one full word then a 3-beat padded tail.
        do_reset();
        for (int i = 1; i <= 11; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        check_eq("eleven_w0", obs_rd, 32'h8765_4321);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        check_eq("eleven_w1", obs_rd, 32'h0000_0BA9);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        check_eq("eleven_done", 32'(obs_done), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("eleven_idle", 32'(obs_active), 32'd0);

        // Pointer wrap with a flush in the middle round.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 24; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            if (r == 2) begin
                cyc(1'b0, 4'h0, 1'b0, 1'b1);
                for (int k = 0; k < 3; k++) cyc(1'b0, 4'h0, 1'b1, 1'b1);
                cyc(1'b0, 4'h0, 1'b0, 1'b1);
                check_eq("wrap_done", 32'(obs_done), 32'd1);
                cyc(1'b0, 4'h0, 1'b0, 1'b0);
            end else begin
                for (int k = 0; k < 3; k++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
            end
        end

        // Reset while the flush is active, then a fresh flush.
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        check_eq("midrst_active", 32'(obs_active), 32'd1);
        do_reset();
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("midrst_no_done", 32'(obs_done), 32'd0);
        scen_partial();

        // Randomized traffic with occasional flushes.
        do_reset();
        r_fl    = 1'b0;
        low_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            r_wr = ($urandom_range(0, 99) < 55);
            r_rd = model_avail() && ($urandom_range(0, 99) < 45);
            if (!r_fl && !flushing && !done_pend && low_cnt > 0 && q.size() > 0
                && $urandom_range(0, 99) < 5) begin
                r_fl = 1'b1;
            end
            cyc(r_wr, 4'($urandom_range(0, 15)), r_rd, r_fl);
            if (r_fl && obs_done) begin
                r_fl    = 1'b0;
                low_cnt = 0;
            end else if (!r_fl) begin
                low_cnt++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
